// File: rtl/app_pkg.sv
// Shared types and default widths for the single-channel analog-memory controller.
package app_pkg;

  localparam int unsigned NCELLS_DEF = 8;
  localparam int unsigned TOT_W_DEF  = 8;
  localparam int unsigned TO_W_DEF   = 8;
  localparam int unsigned META_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    WRITE   = 2'd2,
    REARM   = 2'd3
  } state_e;

endpackage

// File: rtl/app_1ch_amem_if.sv
// Cell-write bus from the channel controller to the analog memory array.
interface app_1ch_amem_if
  import app_pkg::*;
#(
  parameter int unsigned NCELLS = NCELLS_DEF,
  parameter int unsigned TOT_W  = TOT_W_DEF,
  parameter int unsigned META_W = META_W_DEF
);

  localparam int unsigned AW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  logic              wr_valid;
  logic [NCELLS-1:0] cell_sel;
  logic [AW-1:0]     wr_addr;
  logic [TOT_W-1:0]  wr_tot;
  logic [META_W-1:0] wr_meta;
  logic              wr_timeout;

  modport master (
    output wr_valid, cell_sel, wr_addr, wr_tot, wr_meta, wr_timeout
  );

  modport slave (
    input wr_valid, cell_sel, wr_addr, wr_tot, wr_meta, wr_timeout
  );

endinterface

// File: rtl/app_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module app_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/app_1ch_amem.sv
// One photon-processor channel: hit detection, TOT measurement with optional
// timeout, and round-robin commit of each hit into an NCELLS-deep analog memory.
module app_1ch_amem
  import app_pkg::*;
#(
  parameter int unsigned NCELLS = NCELLS_DEF,
  parameter int unsigned TOT_W  = TOT_W_DEF,
  parameter int unsigned TO_W   = TO_W_DEF,
  parameter int unsigned META_W = META_W_DEF
) (
  input  logic              clk,
  input  logic              rst_init,
  input  logic              vcomp,
  input  logic              timeout_en,
  input  logic [TO_W-1:0]   timeout_length,
  input  logic [META_W-1:0] metadata,
  input  logic              resetb_full,
  output logic              tot,
  output logic              busy,
  output logic              full,
  output logic              dropped,
  app_1ch_amem_if.master    wr
);

  localparam int unsigned AW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [TOT_W-1:0] TOT_MAX    = '1;
  localparam logic [CW-1:0]    COUNT_FULL = CW'(NCELLS);

  state_e state_q, state_d;

  logic vcomp_s;
  logic vcomp_d_q;
  logic rise;
  logic timeout_hit;
  logic write_d;

  logic [TOT_W-1:0]  tot_cnt_q, tot_cnt_d;
  logic              to_flag_q, to_flag_d;
  logic [META_W-1:0] meta_q, meta_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              tot_q, tot_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic              dropped_q, dropped_d;
  logic              wr_valid_q, wr_valid_d;
  logic [NCELLS-1:0] cell_sel_q, cell_sel_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [TOT_W-1:0]  wr_tot_q, wr_tot_d;
  logic [META_W-1:0] wr_meta_q, wr_meta_d;
  logic              wr_timeout_q, wr_timeout_d;

  app_sync2 u_sync (
    .clk (clk),
    .rst (rst_init),
    .d_i (vcomp),
    .q_o (vcomp_s)
  );

  assign rise        = vcomp_s & ~vcomp_d_q;
  assign timeout_hit = timeout_en && (timeout_length != '0) &&
                       (32'(tot_cnt_q) == 32'(timeout_length));

  // Next-state, counters, fill state and registered-output inputs
  always_comb begin
    state_d   = state_q;
    tot_cnt_d = tot_cnt_q;
    to_flag_d = to_flag_q;
    meta_d    = meta_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    dropped_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (full_q) begin
            dropped_d = 1'b1;
          end else begin
            state_d   = MEASURE;
            tot_cnt_d = TOT_W'(1);
            to_flag_d = 1'b0;
            meta_d    = metadata;
          end
        end
      end
      MEASURE: begin
        // Timeout wins over a fall arriving in the same cycle
        if (timeout_hit) begin
          state_d   = WRITE;
          to_flag_d = 1'b1;
        end else if (!vcomp_s) begin
          state_d   = WRITE;
          to_flag_d = 1'b0;
        end else if (tot_cnt_q != TOT_MAX) begin
          tot_cnt_d = tot_cnt_q + TOT_W'(1);
        end
      end
      WRITE: begin
        state_d  = REARM;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      REARM: begin
        if (!vcomp_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Fill clear overrides any pointer advance from a concurrent write
    if (!resetb_full) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end

    write_d      = (state_d == WRITE);
    tot_d        = (state_d == MEASURE);
    busy_d       = (state_d != IDLE);
    full_d       = (count_d == COUNT_FULL);
    wr_valid_d   = write_d;
    cell_sel_d   = write_d ? (NCELLS'(1) << wr_ptr_q) : '0;
    wr_addr_d    = write_d ? wr_ptr_q  : wr_addr_q;
    wr_tot_d     = write_d ? tot_cnt_d : wr_tot_q;
    wr_meta_d    = write_d ? meta_d    : wr_meta_q;
    wr_timeout_d = write_d ? to_flag_d : wr_timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst_init) begin
      state_q      <= IDLE;
      vcomp_d_q    <= 1'b0;
      tot_cnt_q    <= '0;
      to_flag_q    <= 1'b0;
      meta_q       <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      tot_q        <= 1'b0;
      busy_q       <= 1'b0;
      full_q       <= 1'b0;
      dropped_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      cell_sel_q   <= '0;
      wr_addr_q    <= '0;
      wr_tot_q     <= '0;
      wr_meta_q    <= '0;
      wr_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vcomp_d_q    <= vcomp_s;
      tot_cnt_q    <= tot_cnt_d;
      to_flag_q    <= to_flag_d;
      meta_q       <= meta_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      tot_q        <= tot_d;
      busy_q       <= busy_d;
      full_q       <= full_d;
      dropped_q    <= dropped_d;
      wr_valid_q   <= wr_valid_d;
      cell_sel_q   <= cell_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_tot_q     <= wr_tot_d;
      wr_meta_q    <= wr_meta_d;
      wr_timeout_q <= wr_timeout_d;
    end
  end

  assign tot           = tot_q;
  assign busy          = busy_q;
  assign full          = full_q;
  assign dropped       = dropped_q;
  assign wr.wr_valid   = wr_valid_q;
  assign wr.cell_sel   = cell_sel_q;
  assign wr.wr_addr    = wr_addr_q;
  assign wr.wr_tot     = wr_tot_q;
  assign wr.wr_meta    = wr_meta_q;
  assign wr.wr_timeout = wr_timeout_q;

endmodule

// File: tb/tb_app_1ch_amem.sv
// Directed self-checking bench for app_1ch_amem: hits, timeout, saturation,
// fill/wrap, clear-during-write and reset mid-event.
module tb_app_1ch_amem;

  logic       clk = 1'b0;
  logic       rst_init;
  logic       vcomp;
  logic       timeout_en;
  logic [7:0] timeout_length;
  logic [7:0] metadata;
  logic       resetb_full;
  logic       tot;
  logic       busy;
  logic       full;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  int         wr_cnt   = 0;
  int         drop_cnt = 0;
  logic [7:0] cap_sel;
  logic [2:0] cap_addr;
  logic [7:0] cap_tot;
  logic [7:0] cap_meta;
  logic       cap_to;

  app_1ch_amem_if #(.NCELLS(8), .TOT_W(8), .META_W(8)) wr_if ();

  app_1ch_amem #(.NCELLS(8), .TOT_W(8), .TO_W(8), .META_W(8)) dut (
    .clk            (clk),
    .rst_init       (rst_init),
    .vcomp          (vcomp),
    .timeout_en     (timeout_en),
    .timeout_length (timeout_length),
    .metadata       (metadata),
    .resetb_full    (resetb_full),
    .tot            (tot),
    .busy           (busy),
    .full           (full),
    .dropped        (dropped),
    .wr             (wr_if)
  );

  always #10 clk = ~clk;

  // Record every write strobe and drop pulse as seen by the memory array
  always @(negedge clk) begin
    if (wr_if.wr_valid === 1'b1) begin
      wr_cnt   <= wr_cnt + 1;
      cap_sel  <= wr_if.cell_sel;
      cap_addr <= wr_if.wr_addr;
      cap_tot  <= wr_if.wr_tot;
      cap_meta <= wr_if.wr_meta;
      cap_to   <= wr_if.wr_timeout;
    end
    if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
  end

  task automatic apply_reset();
    rst_init    = 1'b1;
    vcomp       = 1'b0;
    resetb_full = 1'b1;
    repeat (2) @(negedge clk);
    rst_init = 1'b0;
    @(negedge clk);
  endtask

  task automatic hit(input int n);
    @(negedge clk) vcomp = 1'b1;
    repeat (n) @(negedge clk);
    vcomp = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, tot, full, dropped, wr_if.wr_valid, wr_if.wr_timeout} !== 6'b0 ||
        wr_if.cell_sel !== 8'h00 || wr_if.wr_addr !== 3'd0 ||
        wr_if.wr_tot !== 8'h00 || wr_if.wr_meta !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs busy=%b tot=%b full=%b dropped=%b valid=%b sel=%h addr=%0d wtot=%0d meta=%h to=%b expected all zero",
               busy, tot, full, dropped, wr_if.wr_valid, wr_if.cell_sel, wr_if.wr_addr,
               wr_if.wr_tot, wr_if.wr_meta, wr_if.wr_timeout);
    end
  endtask

  task automatic test_basic_hit();
    int w0;
    w0 = wr_cnt;
    metadata = 8'hA5;
    @(negedge clk) vcomp = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tot !== 1'b1) begin
      errors++;
      $display("FAIL basic_measuring busy=%b tot=%b expected busy=1 tot=1", busy, tot);
    end
    repeat (2) @(negedge clk);
    vcomp = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (wr_cnt !== w0 + 1 || cap_sel !== 8'b0000_0001 || cap_addr !== 3'd0 ||
        cap_tot !== 8'd5 || cap_meta !== 8'hA5 || cap_to !== 1'b0) begin
      errors++;
      $display("FAIL basic_write writes=%0d sel=%b addr=%0d tot=%0d meta=%h to=%b expected writes=%0d sel=00000001 addr=0 tot=5 meta=a5 to=0",
               wr_cnt - w0, cap_sel, cap_addr, cap_tot, cap_meta, cap_to, 1);
    end
    checks++;
    if (busy !== 1'b0 || tot !== 1'b0 || wr_if.cell_sel !== 8'h00 ||
        wr_if.wr_tot !== 8'd5 || wr_if.wr_meta !== 8'hA5) begin
      errors++;
      $display("FAIL basic_idle_hold busy=%b tot=%b sel=%h wtot=%0d meta=%h expected busy=0 tot=0 sel=00 wtot=5 meta=a5",
               busy, tot, wr_if.cell_sel, wr_if.wr_tot, wr_if.wr_meta);
    end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wr_cnt;
    metadata       = 8'h3C;
    timeout_en     = 1'b1;
    timeout_length = 8'd3;
    hit(20);
    checks++;
    if (wr_cnt !== w0 + 1 || cap_tot !== 8'd3 || cap_to !== 1'b1 ||
        cap_addr !== 3'd1 || cap_sel !== 8'b0000_0010 || cap_meta !== 8'h3C) begin
      errors++;
      $display("FAIL timeout_write writes=%0d tot=%0d to=%b addr=%0d sel=%b meta=%h expected writes=1 tot=3 to=1 addr=1 sel=00000010 meta=3c",
               wr_cnt - w0, cap_tot, cap_to, cap_addr, cap_sel, cap_meta);
    end
    hit(4);
    checks++;
    if (wr_cnt !== w0 + 2 || cap_tot !== 8'd3 || cap_to !== 1'b1 || cap_addr !== 3'd2) begin
      errors++;
      $display("FAIL timeout_rearm writes=%0d tot=%0d to=%b addr=%0d expected writes=2 tot=3 to=1 addr=2",
               wr_cnt - w0, cap_tot, cap_to, cap_addr);
    end
  endtask

  task automatic test_timeout_disabled();
    timeout_en     = 1'b0;
    timeout_length = 8'd3;
    hit(300);
    checks++;
    if (cap_tot !== 8'd255 || cap_to !== 1'b0 || cap_addr !== 3'd3) begin
      errors++;
      $display("FAIL sat_en0 tot=%0d to=%b addr=%0d expected tot=255 to=0 addr=3",
               cap_tot, cap_to, cap_addr);
    end
    timeout_en     = 1'b1;
    timeout_length = 8'd0;
    hit(300);
    checks++;
    if (cap_tot !== 8'd255 || cap_to !== 1'b0 || cap_addr !== 3'd4) begin
      errors++;
      $display("FAIL sat_len0 tot=%0d to=%b addr=%0d expected tot=255 to=0 addr=4",
               cap_tot, cap_to, cap_addr);
    end
    timeout_en = 1'b0;
  endtask

  task automatic test_fill_wrap();
    int w0;
    int d0;
    logic [7:0] exp_sel;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      metadata = 8'(i + 16);
      exp_sel  = 8'(1 << i);
      hit(2);
      checks++;
      if (cap_sel !== exp_sel || cap_addr !== 3'(i) || cap_tot !== 8'd2 ||
          cap_meta !== 8'(i + 16)) begin
        errors++;
        $display("FAIL fill_cell%0d sel=%b addr=%0d tot=%0d meta=%h expected sel=%b addr=%0d tot=2 meta=%h",
                 i, cap_sel, cap_addr, cap_tot, cap_meta, exp_sel, i, 8'(i + 16));
      end
      checks++;
      if (full !== (i == 7)) begin
        errors++;
        $display("FAIL fill_full%0d full=%b expected %b", i, full, (i == 7));
      end
    end
    w0 = wr_cnt;
    d0 = drop_cnt;
    hit(2);
    checks++;
    if (drop_cnt !== d0 + 1 || wr_cnt !== w0 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop drops=%0d writes=%0d full=%b expected drops=1 writes=0 full=1",
               drop_cnt - d0, wr_cnt - w0, full);
    end
    @(negedge clk) resetb_full = 1'b0;
    @(negedge clk) resetb_full = 1'b1;
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL fill_clear full=%b expected 0", full);
    end
    hit(2);
    checks++;
    if (wr_cnt !== w0 + 1 || cap_addr !== 3'd0 || cap_sel !== 8'b0000_0001) begin
      errors++;
      $display("FAIL fill_after_clear writes=%0d addr=%0d sel=%b expected writes=1 addr=0 sel=00000001",
               wr_cnt - w0, cap_addr, cap_sel);
    end
  endtask

  task automatic test_clear_during_write();
    logic found;
    logic [7:0] sel_seen;
    logic [2:0] addr_seen;
    apply_reset();
    for (int i = 0; i < 7; i++) hit(2);
    found     = 1'b0;
    sel_seen  = 8'h00;
    addr_seen = 3'd0;
    @(negedge clk) vcomp = 1'b1;
    repeat (2) @(negedge clk);
    vcomp = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (wr_if.wr_valid === 1'b1) begin
        found       = 1'b1;
        sel_seen    = wr_if.cell_sel;
        addr_seen   = wr_if.wr_addr;
        resetb_full = 1'b0;
      end
    end
    @(negedge clk) resetb_full = 1'b1;
    checks++;
    if (!found || sel_seen !== 8'b1000_0000 || addr_seen !== 3'd7) begin
      errors++;
      $display("FAIL clrwr_strobe found=%b sel=%b addr=%0d expected found=1 sel=10000000 addr=7",
               found, sel_seen, addr_seen);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL clrwr_full full=%b expected 0", full);
    end
    hit(2);
    checks++;
    if (cap_addr !== 3'd0 || cap_sel !== 8'b0000_0001) begin
      errors++;
      $display("FAIL clrwr_next addr=%0d sel=%b expected addr=0 sel=00000001", cap_addr, cap_sel);
    end
  endtask

  task automatic test_reset_mid_event();
    int w0;
    apply_reset();
    metadata = 8'h77;
    for (int i = 0; i < 3; i++) hit(2);
    @(negedge clk) vcomp = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy busy=%b expected 1", busy);
    end
    w0       = wr_cnt;
    rst_init = 1'b1;
    vcomp    = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, tot, full, dropped, wr_if.wr_valid, wr_if.wr_timeout} !== 6'b0 ||
        wr_if.cell_sel !== 8'h00 || wr_if.wr_addr !== 3'd0 ||
        wr_if.wr_tot !== 8'h00 || wr_if.wr_meta !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs busy=%b tot=%b full=%b dropped=%b valid=%b sel=%h addr=%0d wtot=%0d meta=%h to=%b expected all zero",
               busy, tot, full, dropped, wr_if.wr_valid, wr_if.cell_sel, wr_if.wr_addr,
               wr_if.wr_tot, wr_if.wr_meta, wr_if.wr_timeout);
    end
    rst_init = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL rstmid_nowrite writes=%0d expected 0", wr_cnt - w0);
    end
    metadata = 8'h5A;
    hit(3);
    checks++;
    if (wr_cnt !== w0 + 1 || cap_addr !== 3'd0 || cap_sel !== 8'b0000_0001 ||
        cap_tot !== 8'd3 || cap_meta !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_next writes=%0d addr=%0d sel=%b tot=%0d meta=%h expected writes=1 addr=0 sel=00000001 tot=3 meta=5a",
               wr_cnt - w0, cap_addr, cap_sel, cap_tot, cap_meta);
    end
  endtask

  initial begin
    rst_init       = 1'b1;
    vcomp          = 1'b0;
    timeout_en     = 1'b0;
    timeout_length = 8'd0;
    metadata       = 8'h00;
    resetb_full    = 1'b1;
    test_reset();
    test_basic_hit();
    test_timeout();
    test_timeout_disabled();
    test_fill_wrap();
    test_clear_during_write();
    test_reset_mid_event();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/app_1ch_amem.md
Name: app_1ch_amem

Overview:
- Digital controller for one Analog Photon Processor channel.
- Detects comparator hits and measures time-over-threshold (TOT) in clock cycles, with an optional timeout.
- Commits each hit to one cell of an NCELLS-deep analog memory: one-hot cell select, TOT, and metadata.
- Sits between the per-channel comparator and the analog memory array/readout. Analog circuitry is outside this block.

Parameters:
- NCELLS, 8, number of analog memory cells (power of two, ≥2).
- TOT_W, 8, TOT counter width.
- TO_W, 8, timeout_length width.
- META_W, 8, metadata width.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst_init  in  1  synchronous active-high reset.
- vcomp  in  1  raw comparator output, asynchronous to clk.
- timeout_en  in  1  enables the TOT timeout.
- timeout_length  in  TO_W  timeout in cycles; 0 = timeout disabled.
- metadata  in  META_W  event tag, latched at hit start.
- resetb_full  in  1  active-low synchronous clear of the memory fill state.
- tot  out  1  high while in MEASURE with vcomp_s=1.
- busy  out  1  high in any state except IDLE.
- wr_valid  out  1  one-cycle cell-write strobe.
- cell_sel  out  NCELLS  one-hot cell being written; zero when wr_valid=0.
- wr_addr  out  clog2(NCELLS)  binary index of the written cell.
- wr_tot  out  TOT_W  measured TOT.
- wr_meta  out  META_W  latched metadata.
- wr_timeout  out  1  event ended by timeout.
- full  out  1  all cells written since the last clear.
- dropped  out  1  one-cycle pulse when a hit is ignored because full=1.

Behaviour:
- Reset (rst_init=1 at a clk edge):
  - state=IDLE; wr_ptr=0; count=0.
  - All outputs 0; synchronizer flops 0.
  - Reset mid-event discards the event with no write.
- vcomp passes through a 2-flop synchronizer to give vcomp_s. vcomp_d is vcomp_s delayed one cycle.
- A rise is vcomp_s=1 & vcomp_d=0.
- Latency: raw vcomp edge → vcomp_s after 2 edges → MEASURE on the following edge.
- IDLE:
  - Rise & !full → MEASURE, tot_cnt=1, latch metadata.
  - Rise & full → dropped=1 for one cycle, stay IDLE.
- MEASURE:
  - vcomp_s=1 → tot_cnt increments, saturating at 2^TOT_W−1.
  - vcomp_s=0 → WRITE, timeout flag=0.
  - timeout_en=1 & timeout_length≠0 & tot_cnt==timeout_length → WRITE, timeout flag=1, tot_cnt frozen. Timeout takes priority over a simultaneous vcomp_s fall.
- WRITE (exactly 1 cycle):
  - wr_valid=1, cell_sel=1<<wr_ptr, wr_addr=wr_ptr.
  - wr_tot=tot_cnt, wr_meta=latched metadata, wr_timeout=flag.
  - Next edge: wr_ptr=(wr_ptr+1) mod NCELLS, count++. Next state is REARM.
- REARM: stay until vcomp_s=0, then IDLE. A long pulse cut by timeout is never re-triggered.
- Fill state:
  - full = (count==NCELLS).
  - wr_ptr wraps to 0 after cell NCELLS−1.
  - No writes occur while full; hits in IDLE are dropped.
- resetb_full=0 at a clk edge: count=0, wr_ptr=0, full=0. No effect on state or an in-flight measurement.
- resetb_full=0 in the same cycle as WRITE: the write strobe is still emitted at the old address, the clear wins, and count ends at 0.
- wr_tot, wr_meta, wr_timeout and wr_addr hold their last values between strobes. cell_sel is 0 outside WRITE.
- Timeout inputs are sampled every cycle. Changing them mid-MEASURE takes effect immediately.
- All outputs are registered.

Decomposition:
- Shared package app_pkg:
  - state enum {IDLE, MEASURE, WRITE, REARM}.
  - Default widths: TOT_W, TO_W, META_W, NCELLS.
- One sub-module: app_sync2, the 2-flop synchronizer with reset.
- FSM, TOT counter and the cell pointer/fill logic live in app_1ch_amem.

Test Plan:
- Basic hit: reset, metadata=8'hA5, vcomp high 5 cycles (after sync) → one wr_valid, cell_sel=8'b0000_0001, wr_addr=0, wr_tot=5, wr_meta=A5, wr_timeout=0; busy returns to 0.
- Timeout: timeout_en=1, timeout_length=3, vcomp high 20 cycles → wr_tot=3, wr_timeout=1; no second write until vcomp falls and rises again.
- Timeout disabled:
  - timeout_en=0, vcomp high 300 cycles → wr_tot=255 (saturated), wr_timeout=0.
  - timeout_en=1, timeout_length=0 → same result.
- Fill/wrap: 8 hits → cell_sel walks bit0…bit7, full=1 after the 8th. 9th hit → dropped pulse, no wr_valid. resetb_full=0 one cycle → full=0; next hit writes cell 0.
- Clear during WRITE: 7 hits, then resetb_full=0 on the 8th hit's WRITE cycle → write to cell 7 emitted, full stays 0, next hit writes cell 0.
- Reset mid-event: rst_init=1 during MEASURE → no wr_valid, all outputs 0, next hit writes cell 0.
